dmem_responder: RTL
===================

# dmem_responder

Data-memory responder serving the CPU's DMEM port (`daddr`/`dwdata`/`we`/`drdata`) and driving the CPU's `external_stall`. It sits between the single-cycle CPU and a synchronous word-wide SRAM with one-cycle read latency plus configurable wait states. Stores complete in one cycle. Loads stall the CPU until the SRAM word is captured, then present it for exactly one commit cycle.

## Interface
Parameters:
- `ADDR_W`, 12, word-address width of the SRAM (`4 * 2**ADDR_W` bytes).
- `WAIT_CYCLES`, 0, extra read wait states beyond the SRAM's one-cycle latency; legal range 0..15.

Ports:
- `clk`  input  1  sole clock; everything is rising-edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `daddr`  input  32  byte address from CPU.
- `dwdata`  input  32  lane-replicated store data from CPU.
- `we`  input  4  per-byte write enable from CPU.
- `mem_rd`  input  1  decoded load indication from CPU, valid in the load's execute cycle.
- `drdata`  output  32  full aligned word returned to CPU; the CPU does the lane extraction.
- `external_stall`  output  1  holds the CPU PC and suppresses register-file write.
- `sram_en`  output  1  SRAM access enable.
- `sram_addr`  output  ADDR_W  SRAM word address, `daddr[ADDR_W+1:2]`.
- `sram_we`  output  4  SRAM byte write enables.
- `sram_wdata`  output  32  SRAM write data, `dwdata` passed through.
- `sram_rdata`  input  32  SRAM read data, valid one edge after `sram_en` with `sram_we==0`.

## Operation
- States: `IDLE`, `WAIT`, `DONE`. Wait counter `cnt` is 4 bits. Capture register `rdata_q` is 32 bits.
- `IDLE`:
  - If `we!=0`, drive `sram_en=1` and `sram_we=we`. The write commits at the edge. No stall, no state change.
  - Else if `mem_rd=1`, drive `sram_en=1` and `sram_we=0`, assert `external_stall`, load `cnt<=WAIT_CYCLES`, go to `WAIT`.
  - Else all SRAM outputs are 0.
- `we!=0` together with `mem_rd=1` is illegal. The write wins and no read starts.
- `WAIT`:
  - Drive `sram_en=1`, `sram_we=0`, and `sram_addr` from the current `daddr`. The address is stable because the PC is held.
  - Assert `external_stall`.
  - If `cnt!=0`, then `cnt<=cnt-1`.
  - Else `rdata_q<=sram_rdata` and go to `DONE`.
- `DONE`: `external_stall=0`, SRAM idle (`sram_en=0`), `drdata=rdata_q`. Go to `IDLE` unconditionally. The CPU commits the load at this edge. The next instruction is then evaluated in `IDLE`, so the same load is never re-issued.
- `we` and `mem_rd` are ignored in `WAIT` and `DONE`; they cannot occur there by construction.
- `drdata=rdata_q` in all states.
- `external_stall = (state==IDLE && mem_rd && we==0) || state==WAIT`, combinational.
- Address bits above `ADDR_W+1` are ignored and alias. Bits [1:0] are ignored here.

## Timing
- Reset values:
  - `state=IDLE`, `cnt=0`, `rdata_q=0`.
  - `drdata=0`, `external_stall=0`.
  - `sram_en=0`, `sram_we=0`.
  - While `reset_n=0`, all combinational outputs are forced to 0.
- Store: zero added latency, written at the same edge the CPU retires it.
- Load with W=`WAIT_CYCLES`:
  - Stall is high for W+2 cycles (the `IDLE` issue cycle plus W+1 `WAIT` cycles).
  - Data is visible in the `DONE` cycle.
  - Total latency is W+3 cycles from first `mem_rd` to the commit edge.
- Back-to-back loads: the second load is issued in the cycle after `DONE`. There is no overlap.
- Reset asserted mid-load: FSM returns to `IDLE` immediately and the stall drops asynchronously. `rdata_q` clears. No partial data is ever presented.

## Structure
- Package `dmem_pkg`:
  - `dmem_state_t` enum (`IDLE`, `WAIT`, `DONE`, 2 bits).
  - `WAIT_CNT_W=4`.
  - `MAX_WAIT_CYCLES=15`.
- Single module; no sub-module.
- SRAM behavioural model `dmem_sram` (1-cycle read, byte-enable write) belongs to the bench, not the RTL.

## Test plan
- Reset with `mem_rd=1` held -> `external_stall=0`, `drdata=0`, `sram_en=0` throughout reset. After release, a read issues on the first edge.
- Store `daddr=0x10`, `we=4'b1111`, `dwdata=0xDEADBEEF`, then a load from `0x10` (W=0) -> stall high 2 cycles, `drdata=0xDEADBEEF` in `DONE`, stall low in `DONE`.
- Byte store `we=4'b0100`, `dwdata=0x5A5A5A5A` to `0x12` over an existing `0x11223344` -> a later load returns `0x115A3344`.
- W=3 load -> stall high exactly 5 cycles, `sram_addr` constant throughout, `DONE` for exactly 1 cycle.
- Back-to-back loads from `0x0` and `0x4` -> two distinct stall windows separated by one `DONE` cycle. Each returns its own word.
- Assert `reset_n=0` during `WAIT` -> stall drops the same cycle and `drdata=0`. After release, a re-issued load returns correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and limits for the CPU data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int WAIT_CNT_W      = 4;
    localparam int MAX_WAIT_CYCLES = 15;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU DMEM port plus SRAM port bundle; slave is the responder, master is its environment.
interface dmem_responder_if #(
    parameter int ADDR_W = 12
) ();

    logic [31:0]       daddr;
    logic [31:0]       dwdata;
    logic [3:0]        we;
    logic              mem_rd;
    logic [31:0]       drdata;
    logic              external_stall;
    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_we;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    modport slave (
        input  daddr, dwdata, we, mem_rd, sram_rdata,
        output drdata, external_stall, sram_en, sram_addr, sram_we, sram_wdata
    );

    modport master (
        output daddr, dwdata, we, mem_rd, sram_rdata,
        input  drdata, external_stall, sram_en, sram_addr, sram_we, sram_wdata
    );

endinterface

// File: rtl/dmem_responder.sv
// Bridges the single-cycle CPU DMEM port to a synchronous SRAM: stores pass straight
// through, loads stall the CPU until the word is captured and then present it for one cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_responder_if.slave   bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    dmem_state_t           state;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [31:0]           rdata_q;

    logic wr_issue;
    logic rd_issue;
    logic waiting;

    // Everything combinational is qualified by reset_n so a mid-load reset drops the stall at once.
    always_comb begin
        wr_issue = 1'b0;
        rd_issue = 1'b0;
        waiting  = 1'b0;
        if (reset_n) begin
            wr_issue = (state == IDLE) && (bus.we != 4'b0000);
            rd_issue = (state == IDLE) && (bus.we == 4'b0000) && bus.mem_rd;
            waiting  = (state == WAIT);
        end
    end

    assign bus.sram_en        = wr_issue | rd_issue | waiting;
    assign bus.sram_we        = wr_issue ? bus.we : 4'b0000;
    assign bus.sram_wdata     = wr_issue ? bus.dwdata : 32'h0;
    assign bus.sram_addr      = bus.sram_en ? bus.daddr[ADDR_W+1:2] : '0;
    assign bus.external_stall = rd_issue | waiting;
    assign bus.drdata         = reset_n ? rdata_q : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_issue) begin
                        cnt   <= WAIT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rdata_q <= bus.sram_rdata;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // The CPU commits the load on this edge; the next instruction starts in IDLE.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-offset and aliased upper address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.daddr[31:ADDR_W+2], bus.daddr[1:0]};

endmodule
